// File: rtl/arb2_stream.sv
// rtl/arb2_stream.sv - two-channel round-robin stream arbiter feeding the 2:1 data mux
module arb2_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  input  logic             in2_valid,
  input  logic [WIDTH-1:0] in2_data,
  output logic             in2_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             sel,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  // prio = 1 favours in1 on a tie, prio = 0 favours in2
  logic prio;
  logic load_en;
  logic grant1;
  logic grant2;

  // Grant decision; the two grants are mutually exclusive by construction
  always_comb begin
    load_en   = !out_valid | out_ready;
    grant1    = in1_valid & (!in2_valid | prio);
    grant2    = in2_valid & (!in1_valid | !prio);
    in1_ready = rst_n & load_en & grant1;
    in2_ready = rst_n & load_en & grant2;
  end

  // Output register, priority pointer and grant counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      sel       <= 1'b0;
      prio      <= 1'b1;
      cnt1      <= '0;
      cnt2      <= '0;
    end else if (load_en) begin
      if (grant1) begin
        out_valid <= 1'b1;
        out_data  <= in1_data;
        sel       <= 1'b1;
        prio      <= 1'b0;
        cnt1      <= cnt1 + CNT_W'(1);
      end else if (grant2) begin
        out_valid <= 1'b1;
        out_data  <= in2_data;
        sel       <= 1'b0;
        prio      <= 1'b1;
        cnt2      <= cnt2 + CNT_W'(1);
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb2_stream.sv
// tb/tb_arb2_stream.sv - self-checking bench for arb2_stream
module tb_arb2_stream;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in1_valid, in2_valid, out_ready;
  logic [WIDTH-1:0] in1_data, in2_data;
  logic             in1_ready, in2_ready, out_valid, sel;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] cnt1, cnt2;

  int checks   = 0;
  int failures = 0;

  // behavioural reference: one-entry holding slot, last winner, counters
  bit             m_full;
  logic [7:0]     m_data;
  bit             m_sel;
  int             m_last;
  int             m_c1, m_c2;
  logic           s_r1, s_r2;

  typedef struct {
    bit         rstn;
    bit         v1;
    logic [7:0] d1;
    bit         v2;
    logic [7:0] d2;
    bit         ordy;
    bit         er1;
    bit         er2;
    bit         eov;
    logic [7:0] ed;
    bit         esel;
    int         ec1;
    int         ec2;
  } vec_t;

  vec_t tbl[22];

  arb2_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .in2_valid(in2_valid), .in2_data(in2_data), .in2_ready(in2_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sel(sel), .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit rstn, bit v1, logic [7:0] d1, bit v2, logic [7:0] d2, bit ordy,
                              bit er1, bit er2, bit eov, logic [7:0] ed, bit esel, int ec1, int ec2);
    vec_t v;
    v.rstn = rstn; v.v1 = v1; v.d1 = d1; v.v2 = v2; v.d2 = d2; v.ordy = ordy;
    v.er1 = er1; v.er2 = er2; v.eov = eov; v.ed = ed; v.esel = esel; v.ec1 = ec1; v.ec2 = ec2;
    return v;
  endfunction

  // one clock: drive, check readies against the model, clock, check registered outputs
  task automatic cyc(input bit rstn, input bit v1, input logic [7:0] d1,
                     input bit v2, input logic [7:0] d2, input bit ordy);
    int win;
    bit take;
    rst_n = rstn; in1_valid = v1; in1_data = d1; in2_valid = v2; in2_data = d2; out_ready = ordy;
    #1;
    take = rstn && (!m_full || ordy);
    if (!take)        win = 0;
    else if (v1 && v2) win = (m_last == 2) ? 1 : 2;
    else if (v1)      win = 1;
    else if (v2)      win = 2;
    else              win = 0;
    s_r1 = in1_ready;
    s_r2 = in2_ready;
    chk("in1_ready", {31'd0, in1_ready}, {31'd0, win == 1});
    chk("in2_ready", {31'd0, in2_ready}, {31'd0, win == 2});
    @(posedge clk);
    if (!rstn) begin
      m_full = 0; m_data = 8'h00; m_sel = 0; m_last = 2; m_c1 = 0; m_c2 = 0;
    end else if (take) begin
      if (win == 0) m_full = 0;
      else begin
        m_full = 1;
        m_data = (win == 1) ? d1 : d2;
        m_sel  = (win == 1);
        m_last = win;
        if (win == 1) m_c1 = (m_c1 + 1) % CMOD;
        else          m_c2 = (m_c2 + 1) % CMOD;
      end
    end
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_full});
    chk("out_data",  {24'd0, out_data},  {24'd0, m_data});
    chk("sel",       {31'd0, sel},       {31'd0, m_sel});
    chk("cnt1",      {28'd0, cnt1},      m_c1);
    chk("cnt2",      {28'd0, cnt2},      m_c2);
  endtask

  initial begin
    m_full = 0; m_data = 0; m_sel = 0; m_last = 2; m_c1 = 0; m_c2 = 0;

    tbl[0]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(1, 1, 8'hA5, 0, 8'h00, 1,  1, 0,  1, 8'hA5, 1, 1, 0);
    tbl[2]  = mk(0, 0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h00, 0, 0, 0);
    tbl[3]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 1, 1, 0);
    tbl[4]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 0, 1, 1);
    tbl[5]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 1, 2, 1);
    tbl[6]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 0, 2, 2);
    tbl[7]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  1, 0,  1, 8'h11, 1, 3, 2);
    tbl[8]  = mk(1, 1, 8'h11, 1, 8'h22, 1,  0, 1,  1, 8'h22, 0, 3, 3);
    tbl[9]  = mk(1, 1, 8'h33, 0, 8'h00, 1,  1, 0,  1, 8'h33, 1, 4, 3);
    tbl[10] = mk(1, 1, 8'h44, 1, 8'h55, 0,  0, 0,  1, 8'h33, 1, 4, 3);
    tbl[11] = mk(1, 1, 8'h44, 1, 8'h55, 0,  0, 0,  1, 8'h33, 1, 4, 3);
    tbl[12] = mk(1, 1, 8'h44, 1, 8'h55, 0,  0, 0,  1, 8'h33, 1, 4, 3);
    tbl[13] = mk(1, 1, 8'h44, 1, 8'h55, 0,  0, 0,  1, 8'h33, 1, 4, 3);
    tbl[14] = mk(1, 1, 8'h44, 1, 8'h55, 1,  0, 1,  1, 8'h55, 0, 4, 4);
    tbl[15] = mk(1, 0, 8'h00, 1, 8'h66, 1,  0, 1,  1, 8'h66, 0, 4, 5);
    tbl[16] = mk(1, 0, 8'h00, 1, 8'h66, 1,  0, 1,  1, 8'h66, 0, 4, 6);
    tbl[17] = mk(1, 0, 8'h00, 1, 8'h66, 1,  0, 1,  1, 8'h66, 0, 4, 7);
    tbl[18] = mk(1, 1, 8'h77, 1, 8'h88, 1,  1, 0,  1, 8'h77, 1, 5, 7);
    tbl[19] = mk(1, 1, 8'h99, 1, 8'hAA, 0,  0, 0,  1, 8'h77, 1, 5, 7);
    tbl[20] = mk(0, 1, 8'h99, 1, 8'hAA, 0,  0, 0,  0, 8'h00, 0, 0, 0);
    tbl[21] = mk(1, 1, 8'h99, 1, 8'hAA, 1,  1, 0,  1, 8'h99, 1, 1, 0);

    for (int i = 0; i < 22; i++) begin
      cyc(tbl[i].rstn, tbl[i].v1, tbl[i].d1, tbl[i].v2, tbl[i].d2, tbl[i].ordy);
      chk($sformatf("tbl%0d_r1", i),   {31'd0, s_r1},      {31'd0, tbl[i].er1});
      chk($sformatf("tbl%0d_r2", i),   {31'd0, s_r2},      {31'd0, tbl[i].er2});
      chk($sformatf("tbl%0d_ov", i),   {31'd0, out_valid}, {31'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_data", i), {24'd0, out_data},  {24'd0, tbl[i].ed});
      chk($sformatf("tbl%0d_sel", i),  {31'd0, sel},       {31'd0, tbl[i].esel});
      chk($sformatf("tbl%0d_cnt1", i), {28'd0, cnt1},      tbl[i].ec1);
      chk($sformatf("tbl%0d_cnt2", i), {28'd0, cnt2},      tbl[i].ec2);
    end

    // counter wrap: 2^CNT_W - 1 in1 grants, then one more
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    for (int i = 0; i < CMOD - 1; i++) cyc(1, 1, 8'(i), 0, 8'h00, 1);
    chk("wrap_pre_cnt1", {28'd0, cnt1}, CMOD - 1);
    cyc(1, 1, 8'hEE, 0, 8'h00, 1);
    chk("wrap_cnt1", {28'd0, cnt1}, 0);
    chk("wrap_cnt2", {28'd0, cnt2}, 0);

    // randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb2_stream.md
# arb2_stream

Two-channel round-robin stream arbiter that sits directly upstream of the 2:1 data mux. It accepts words from two valid/ready sources and picks one per cycle. It registers the chosen word together with the select value the mux's `cntrl` input consumes, and presents both on one valid/ready output. Fairness is strict alternation whenever both sources are waiting.

## Interface
Parameters:
- `WIDTH`, 8, data width of each channel.
- `CNT_W`, 16, width of the per-channel grant counters.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in1_valid`  input  1  source 1 has a word.
- `in1_data`  input  WIDTH  source 1 word.
- `in1_ready`  output  1  source 1 word is accepted this cycle.
- `in2_valid`  input  1  source 2 has a word.
- `in2_data`  input  WIDTH  source 2 word.
- `in2_ready`  output  1  source 2 word is accepted this cycle.
- `out_valid`  output  1  output register holds a word.
- `out_ready`  input  1  downstream accepts the output word.
- `out_data`  output  WIDTH  registered word.
- `sel`  output  1  source of the current word: 1 = in1, 0 = in2. Same polarity as the mux `cntrl`.
- `cnt1`  output  CNT_W  number of grants to in1.
- `cnt2`  output  CNT_W  number of grants to in2.

## Operation
- Output register: one entry holding `out_data`, `sel` and `out_valid`.
- `load_en = !out_valid | out_ready`. The register can take a new word when it is empty or being drained in the same cycle.
- Priority register `prio` chooses the winner when both sources are valid:
  - `prio = 1` favours in1; `prio = 0` favours in2.
- Grant rules, evaluated only when `load_en = 1`:
  - Only in1 valid: grant in1.
  - Only in2 valid: grant in2.
  - Both valid: grant the channel named by `prio`.
  - Neither valid: no grant.
- `inX_ready = load_en & grantX`. The readies are combinational from the valids, `out_ready` and state, and are never asserted for both channels at once.
- A granted word enters the register at the next edge:
  - `out_valid` is set to 1.
  - `out_data` takes the granted data.
  - `sel` records the granted channel.
  - `prio` toggles to point at the channel that was not granted.
  - The granted channel's counter increments.
- `load_en = 1` with no grant: `out_valid` goes to 0, and `out_data`/`sel` hold their last values.
- While `out_valid = 1` and `out_ready = 0`, `out_data` and `sel` are frozen, both readies are 0, and `prio` holds.
- Counters wrap modulo 2^CNT_W with no saturation.

## Timing
- Reset (`rst_n = 0` at an edge) takes effect at that edge, including mid-transfer; any held word is discarded. Values after reset:
  - `out_valid = 0`, `out_data = 0`, `sel = 0`, `prio = 1`, `cnt1 = 0`, `cnt2 = 0`.
- While `rst_n = 0`, `in1_ready` and `in2_ready` are forced to 0.
- Latency: a word accepted at edge N appears with `out_valid = 1` after edge N.
- Throughput: one word per cycle when `out_ready` is held high, including back-to-back accept and drain in the same cycle.
- Both sources continuously valid with `out_ready = 1`: grants alternate every cycle, starting with in1 after reset.
- A handshake completes only when the valid and the matching ready are both high at the edge. Sources must hold data stable while valid and not ready.

## Test plan
- Reset, then `in1_valid = 1`, `in1_data = 8'hA5`, `in2_valid = 0`, `out_ready = 1`:
  - `in1_ready = 1` in the first cycle.
  - Next cycle: `out_valid = 1`, `out_data = A5`, `sel = 1`, `cnt1 = 1`.
- Both sources valid with constant data 8'h11 (in1) and 8'h22 (in2), `out_ready = 1`, 6 cycles:
  - Output sequence 11, 22, 11, 22, 11, 22.
  - `sel` sequence 1, 0, 1, 0, 1, 0.
  - Final `cnt1 = 3`, `cnt2 = 3`.
- Word 8'h33 held in the register, `out_ready = 0` for 4 cycles, both sources valid:
  - Both readies stay 0 and `out_data = 33` is stable throughout.
  - When `out_ready` rises, the grant goes to the channel opposite the one that produced 33.
- Only in2 valid for 3 cycles, then both valid:
  - Three in2 grants, then in1 wins, because `prio` points at in1 after the in2 grants.
- Assert `rst_n = 0` for one cycle while `out_valid = 1` and `out_ready = 0`:
  - After that edge, `out_valid = 0`, `out_data = 0`, `sel = 0` and both counters are 0.
  - The next grant with both sources valid goes to in1.
- Preload `cnt1` to 2^CNT_W − 1 by running that many in1-only grants, then one more in1 grant:
  - `cnt1` wraps to 0 and `cnt2` is unchanged.
